// File: rtl/interface_controller.sv
// Handshake sequencer for the stream-cipher pin interface: walks IDLE->CAPTURE->PROCESS->ACK,
// holding off the host acknowledge until the datapath finishes, with a byte counter and sticky error.
module interface_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               input_request,
  input  logic               input_byte_pulse,
  input  logic               is_key_pulsed,
  input  logic               reset_hash_pulse,
  input  logic               datapath_done,
  output logic [2:0]         fsm_state,
  output logic               input_ack,
  output logic               busy,
  output logic               error,
  output logic [COUNT_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    PROCESS = 3'd2,
    ACK     = 3'd3
  } interface_state_t;

  // The timeout counter only ever needs to reach TIMEOUT_CYCLES-1 before PROCESS is left.
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  interface_state_t   state_q, state_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (input_request) state_d = CAPTURE;
      end
      CAPTURE: begin
        // Hash reset has priority over a simultaneous byte pulse.
        if (reset_hash_pulse) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ACK;
        end else if (input_byte_pulse) begin
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = PROCESS;
          if (!is_key_pulsed) cnt_d = sat_inc(cnt_q);
        end else begin
          err_d   = 1'b1;
          state_d = ACK;
        end
      end
      PROCESS: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (datapath_done) begin
          state_d = ACK;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!input_request) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Acknowledge is registered off the next state so it is high in exactly the ACK cycles.
  assign ack_d = (state_d == ACK);

  assign fsm_state  = state_q;
  assign input_ack  = ack_q;
  assign busy       = (state_q != IDLE);
  assign error      = err_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_interface_controller.sv
// Bench for interface_controller: directed handshake scenarios plus randomized pin activity,
// compared every cycle against a transaction-level reference model.
module tb_interface_controller;
  localparam int TMO     = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          req = 1'b0, bp = 1'b0, key = 1'b0, hp = 1'b0, done = 1'b0;
  logic [2:0]    fsm;
  logic          ack, busy, err;
  logic [CW-1:0] bc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  interface_controller #(.TIMEOUT_CYCLES(TMO), .COUNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .input_request(req), .input_byte_pulse(bp),
    .is_key_pulsed(key), .reset_hash_pulse(hp), .datapath_done(done),
    .fsm_state(fsm), .input_ack(ack), .busy(busy), .error(err), .byte_count(bc)
  );

  // Reference model: phase of the handshake, a PROCESS deadline in absolute cycles, counters.
  typedef struct {
    int st;
    bit ack;
    bit err;
    int cnt;
    int cyc;
    int deadline;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.ack = 0; r.err = 0; r.cnt = 0; r.cyc = 0; r.deadline = 0;
    return r;
  endfunction

  function automatic model_t step(model_t c, bit rq, bit hb, bit by, bit ky, bit dn);
    model_t n;
    n = c;
    n.cyc = c.cyc + 1;
    if (c.st == 0) begin
      if (rq) n.st = 1;
    end else if (c.st == 1) begin
      if (hb) begin
        n.cnt = 0; n.err = 0; n.st = 3;
      end else if (by) begin
        n.err = 0; n.st = 2; n.deadline = n.cyc + TMO;
        if (!ky && n.cnt < CNT_MAX) n.cnt = n.cnt + 1;
      end else begin
        n.err = 1; n.st = 3;
      end
    end else if (c.st == 2) begin
      if (dn) n.st = 3;
      else if (n.cyc == c.deadline) begin
        n.err = 1; n.st = 3;
      end
    end else begin
      if (!rq) n.st = 0;
    end
    n.ack = (n.st == 3);
    return n;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) m <= model_reset();
    else       m <= step(m, req, hp, bp, key, done);
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("fsm_state", 32'(fsm), m.st);
    chk("input_ack", 32'(ack), int'(m.ack));
    chk("busy", 32'(busy), (m.st != 0) ? 1 : 0);
    chk("error", 32'(err), int'(m.err));
    chk("byte_count", 32'(bc), m.cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host transaction from IDLE; done_after<0 means no datapath_done (timeout).
  task automatic txn(input bit hb, input bit by, input bit ky, input int done_after, input int hold);
    bit to_process;
    int exp_err;
    to_process = by && !hb;
    req = 1'b1;
    tick();
    chk("txn_capture", 32'(fsm), 1);
    hp = hb; bp = by; key = ky;
    tick();
    hp = 1'b0; bp = 1'b0; key = 1'b0;
    chk("txn_after_capture", 32'(fsm), to_process ? 2 : 3);
    chk("txn_err_after_capture", 32'(err), (hb || by) ? 0 : 1);
    if (to_process) begin
      if (done_after >= 0) begin
        repeat (done_after) tick();
        chk("txn_wait_no_ack", 32'(ack), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
      end else begin
        repeat (TMO - 1) tick();
        chk("txn_pre_timeout", 32'(fsm), 2);
        tick();
      end
    end
    exp_err = (hb || (by && done_after >= 0)) ? 0 : 1;
    chk("txn_ack", 32'(ack), 1);
    chk("txn_ack_state", 32'(fsm), 3);
    chk("txn_err", 32'(err), exp_err);
    repeat (hold) tick();
    chk("txn_ack_held", 32'(ack), 1);
    req = 1'b0;
    tick();
    chk("txn_idle", 32'(fsm), 0);
    chk("txn_ack_drop", 32'(ack), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with request high.
    nrst = 1'b0; req = 1'b1;
    repeat (3) tick();
    chk("rst_fsm", 32'(fsm), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_cnt", 32'(bc), 0);
    chk("rst_err", 32'(err), 0);
    nrst = 1'b1;
    tick();
    chk("rst_release_capture", 32'(fsm), 1);
    bp = 1'b1; key = 1'b0;
    tick();
    bp = 1'b0;
    chk("first_byte_process", 32'(fsm), 2);
    chk("first_byte_cnt", 32'(bc), 1);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("first_byte_ack", 32'(ack), 1);
    tick();
    req = 1'b0;
    tick();
    chk("first_byte_idle", 32'(fsm), 0);

    // Key byte leaves the count alone; two more data bytes then a hash reset.
    txn(1'b0, 1'b1, 1'b1, 0, 0);
    chk("key_cnt", 32'(bc), 1);
    txn(1'b0, 1'b1, 1'b0, 0, 1);
    txn(1'b0, 1'b1, 1'b0, 3, 0);
    chk("three_bytes_cnt", 32'(bc), 3);
    chk("model_three_bytes", 32'(m.cnt), 3);
    txn(1'b1, 1'b0, 1'b0, 0, 2);
    chk("hash_cnt", 32'(bc), 0);

    // Timeout, then recovery; done exactly on the expiry cycle is a success.
    txn(1'b0, 1'b1, 1'b0, -1, 1);
    chk("timeout_err", 32'(err), 1);
    txn(1'b0, 1'b1, 1'b0, 0, 0);
    chk("recover_err", 32'(err), 0);
    txn(1'b0, 1'b1, 1'b0, TMO - 1, 0);
    chk("expiry_done_err", 32'(err), 0);

    // Protocol fault and pulse priority.
    txn(1'b0, 1'b0, 1'b0, 0, 0);
    chk("fault_err", 32'(err), 1);
    txn(1'b1, 1'b1, 1'b0, 0, 0);
    chk("both_pulses_cnt", 32'(bc), 0);
    chk("both_pulses_err", 32'(err), 0);

    // Saturation of the counter.
    for (int i = 0; i < CNT_MAX + 2; i++) txn(1'b0, 1'b1, 1'b0, 0, 0);
    chk("sat_cnt", 32'(bc), CNT_MAX);
    chk("model_sat_cnt", 32'(m.cnt), CNT_MAX);

    // Reset in PROCESS coinciding with done.
    req = 1'b1;
    tick();
    bp = 1'b1;
    tick();
    bp = 1'b0;
    tick();
    chk("midrst_in_process", 32'(fsm), 2);
    done = 1'b1; nrst = 1'b0;
    #1;
    chk("midrst_fsm", 32'(fsm), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_cnt", 32'(bc), 0);
    req = 1'b0;
    tick();
    done = 1'b0; nrst = 1'b1;
    tick();
    tick();
    chk("midrst_after_fsm", 32'(fsm), 0);
    chk("midrst_after_ack", 32'(ack), 0);

    // Randomized pin activity, including stray pulses and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 3) req = ~req;
      hp   = ($urandom_range(0, 5) == 0);
      bp   = ($urandom_range(0, 2) != 0);
      key  = ($urandom_range(0, 3) == 0);
      done = ($urandom_range(0, 5) == 0);
      nrst = ($urandom_range(0, 499) != 0);
      tick();
    end
    nrst = 1'b1; req = 1'b0; hp = 1'b0; bp = 1'b0; key = 1'b0; done = 1'b0;
    repeat (TMO + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interface_controller.md
# interface_controller

Sequences the chip-pin 4-phase input handshake for the stream-cipher interface. Owns the `interface_state_t` FSM consumed by the pin reader, waits for the reader's single-cycle pulses, then holds off the host until the cipher/hash datapath reports completion. Only after that does it return the acknowledge. Also keeps a saturating count of accepted bytes and a sticky error flag for the host.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum PROCESS dwell, in cycles, before forced completion with an error.
- `COUNT_W`, default 16: width of `byte_count`.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `input_request` in 1: host request pin, already synchronous to `clk`.
- `input_byte_pulse` in 1: reader pulse indicating a byte/key was captured.
- `is_key_pulsed` in 1: reader flag qualifying `input_byte_pulse`.
- `reset_hash_pulse` in 1: reader pulse indicating a hash-reset request.
- `datapath_done` in 1: single-cycle completion pulse from the cipher/hash datapath.
- `fsm_state` out 3 (`interface_state_t`): current state, fed back to the reader.
- `input_ack` out 1: host acknowledge pin.
- `busy` out 1: high whenever `fsm_state` is not IDLE.
- `error` out 1: sticky fault flag.
- `byte_count` out `COUNT_W`: number of accepted non-key data bytes since the last hash reset.

## Operation
- States (`interface_state_t` encoding): IDLE=0, CAPTURE=1, PROCESS=2, ACK=3.
- **IDLE**
  - `input_ack`=0.
  - If `input_request`=1: go to CAPTURE. The reader samples in this same cycle because it sees IDLE.
- **CAPTURE** lasts exactly 1 cycle and inspects the reader pulses.
  - `reset_hash_pulse`=1: clear `byte_count`, clear `error`, go to ACK. Hash reset completes in one cycle and does not wait for `datapath_done`.
  - Otherwise, `input_byte_pulse`=1: clear `error`, load the timeout counter with 0, go to PROCESS. If `is_key_pulsed`=0, increment `byte_count`, saturating at all-ones.
  - Neither pulse: set `error`, go to ACK. This covers a protocol fault such as a request glitch.
  - Both pulses in the same cycle: the reset-hash branch wins.
- **PROCESS**
  - Increment the timeout counter each cycle.
  - `datapath_done`=1: go to ACK.
  - Otherwise, counter == `TIMEOUT_CYCLES`-1: set `error`, go to ACK.
  - `datapath_done` in the expiry cycle: treated as success, `error` not set.
- **ACK**
  - `input_ack`=1, registered, so it is high in every ACK cycle.
  - Stay in ACK while `input_request`=1.
  - `input_request`=0: go to IDLE; `input_ack` drops with the transition.
- `datapath_done` outside PROCESS is ignored. Stray reader pulses outside CAPTURE are ignored.
- `error` is cleared only by reset or by a successfully captured new request.
- Reset values:
  - `fsm_state`=IDLE
  - `input_ack`=0
  - `busy`=0
  - `error`=0
  - `byte_count`=0
  - timeout counter=0
- Asserting reset mid-transaction returns to IDLE immediately with `input_ack`=0. If the host still holds `input_request`=1 after reset releases, that is treated as a new request.

## Timing
- All outputs are registered. `busy` is decoded from the state register.
- Request sampled high in IDLE at cycle T:
  - CAPTURE at T+1; the reader pulse is visible at T+1.
  - PROCESS at T+2.
- `datapath_done` at cycle D (while in PROCESS): ACK and `input_ack`=1 from D+1.
- Request low sampled at cycle R (while in ACK): IDLE and `input_ack`=0 from R+1. The earliest next request can be accepted at R+1.
- Reset-hash transaction: `input_ack` rises at T+2, a minimum of 2 cycles request-to-ack.
- Byte transaction: minimum 3 cycles request-to-ack, when `datapath_done` arrives at T+2.
- Timeout: with `TIMEOUT_CYCLES`=N, entering PROCESS at T+2 with no done gives ACK at T+2+N.
- `byte_count` and `error` updates are visible the cycle after CAPTURE.

## Test plan
- **Reset.** Hold `nrst`=0 for 3 cycles with `input_request`=1, then release.
  - During reset: `fsm_state`=0, `input_ack`=0, `byte_count`=0, `error`=0.
  - After release: CAPTURE on the first edge.
- **Data byte.** Request with `input_byte_pulse`=1 and `is_key_pulsed`=0 at T+1, `datapath_done` at T+4.
  - `input_ack`=1 from T+5.
  - `byte_count`=1.
  - Dropping `input_request` at T+7 gives `input_ack`=0 and IDLE at T+8.
- **Key byte, then hash reset.**
  - Key byte leaves `byte_count` unchanged.
  - After 3 data bytes (`byte_count`=3), a reset-hash request gives `byte_count`=0 and `input_ack` at T+2, with no `datapath_done` needed.
- **Timeout.** With `TIMEOUT_CYCLES`=8 and no `datapath_done`:
  - ACK at T+10 with `error`=1.
  - The next good transaction clears `error` the cycle after its CAPTURE.
- **Protocol fault and priority.**
  - CAPTURE with no pulse: `error`=1, then ACK.
  - Both pulses in CAPTURE: reset-hash path taken and `byte_count` cleared.
  - `byte_count` at 0xFFFF plus one more data byte stays 0xFFFF.
- **Mid-transaction reset.** Assert `nrst` in PROCESS while `datapath_done` pulses in the same cycle: IDLE with `input_ack`=0, and the done pulse is lost.
